// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier issue/retire stage: default operand
// width, FSM state encoding and a constant-width helper.
package mult_pkg;

  localparam int DEF_OP_W = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_e;

  // Bits needed to index 'value' distinct items (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO; wrapping pointers with a separate occupancy count
// driving full/empty. Push into a full FIFO is accepted when a pop frees a slot.
module sync_fifo
  import mult_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_OP_W,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_rdata,
  output logic               o_full,
  output logic               o_empty,
  output logic [clog2(DEPTH):0] o_count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/retire wrapper around the sequential shift-add multiplier core: queues
// operand pairs, runs one job at a time, holds the product for the consumer.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int OP_W       = DEF_OP_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_mplier,
  input  logic [OP_W-1:0]   in_mcand,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_mplier,
  output logic [OP_W-1:0]   mul_mcand,
  input  logic              mul_ready,
  input  logic [2*OP_W-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] out_product,
  output logic              out_err,
  output logic              busy
);

  localparam int PROD_W = 2 * OP_W;
  localparam int TMR_W  = clog2(TIMEOUT + 1);
  localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;

  state_e              r_state;
  logic                r_start;
  logic                r_out_valid;
  logic                r_out_err;
  logic [OP_W-1:0]     r_mplier;
  logic [OP_W-1:0]     r_mcand;
  logic [PROD_W-1:0]   r_product;
  logic [TMR_W-1:0]    r_timer;

  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CNT_W-1:0]    w_fifo_count;
  logic [PROD_W-1:0]   w_fifo_head;
  logic                w_push;
  logic                w_pop;
  logic                w_can_issue;
  logic                w_timeout;

  assign w_push      = in_valid && !w_fifo_full;
  assign w_can_issue = !w_fifo_empty && mul_ready;
  // A finished result leaving HOLD lets the next job pop in the same cycle.
  assign w_pop       = (r_state == S_IDLE || (r_state == S_HOLD && out_ready)) && w_can_issue;
  assign w_timeout   = (r_timer == TMR_W'(TIMEOUT - 1));

  sync_fifo #(
    .WIDTH (PROD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_op_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_wdata ({in_mplier, in_mcand}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_start     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_mplier    <= '0;
      r_mcand     <= '0;
      r_product   <= '0;
      r_timer     <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_mplier <= w_fifo_head[PROD_W-1:OP_W];
            r_mcand  <= w_fifo_head[OP_W-1:0];
            r_start  <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (w_timeout) begin
            r_product   <= '0;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
            if (!mul_ready) r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // A completion seen on the last allowed cycle still counts as a result.
          if (mul_ready) begin
            r_product   <= mul_product;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else if (w_timeout) begin
            r_product   <= '0;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            if (w_pop) begin
              r_mplier <= w_fifo_head[PROD_W-1:OP_W];
              r_mcand  <= w_fifo_head[OP_W-1:0];
              r_start  <= 1'b1;
              r_state  <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = !w_fifo_full;
  assign mul_start   = r_start;
  assign mul_mplier  = r_mplier;
  assign mul_mcand   = r_mcand;
  assign out_valid   = r_out_valid;
  assign out_product = r_product;
  assign out_err     = r_out_err;
  assign busy        = (r_state != S_IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural shift-add core model
// (switchable to a stub that never leaves ready) and a result scoreboard.
module tb_mult_issue_ctrl;

  localparam int OP_W = 4;
  localparam int PW   = 2 * OP_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OP_W-1:0] in_mplier = '0;
  logic [OP_W-1:0] in_mcand = '0;
  logic          mul_start;
  logic [OP_W-1:0] mul_mplier;
  logic [OP_W-1:0] mul_mcand;
  logic          mul_ready;
  logic [PW-1:0] mul_product;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] out_product;
  logic          out_err;
  logic          busy;

  always #5 clk = ~clk;

  mult_issue_ctrl #(.OP_W(OP_W), .FIFO_DEPTH(4), .TIMEOUT(31)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mplier   (in_mplier),
    .in_mcand    (in_mcand),
    .mul_start   (mul_start),
    .mul_mplier  (mul_mplier),
    .mul_mcand   (mul_mcand),
    .mul_ready   (mul_ready),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_err     (out_err),
    .busy        (busy)
  );

  // Core model: drops ready after start, multiplies over 4 cycles, raises ready.
  logic            core_stub = 1'b0;
  logic            core_ready;
  logic [2:0]      core_cnt;
  logic [OP_W-1:0] core_a, core_b;
  logic [PW-1:0]   core_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_ready <= 1'b1;
      core_cnt   <= '0;
      core_a     <= '0;
      core_b     <= '0;
      core_prod  <= '0;
    end else if (mul_start && core_ready && !core_stub) begin
      core_ready <= 1'b0;
      core_cnt   <= 3'd3;
      core_a     <= mul_mplier;
      core_b     <= mul_mcand;
    end else if (!core_ready) begin
      if (core_cnt == 3'd0) begin
        core_ready <= 1'b1;
        core_prod  <= PW'(core_a) * PW'(core_b);
      end else begin
        core_cnt <= core_cnt - 3'd1;
      end
    end
  end

  assign mul_ready   = core_ready;
  assign mul_product = core_stub ? 8'hA5 : core_prod;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;
  int n_results = 0;
  int cycle = 0;
  int last_start_cycle = 0;
  int first_valid_cycle = 0;
  logic [PW:0] exp_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: start-pulse width, operand stability, scoreboard pop.
  logic            prev_start = 1'b0;
  logic            prev_valid = 1'b0;
  logic            job_active = 1'b0;
  logic [OP_W-1:0] job_a, job_b;
  logic [PW:0]     exp_item;

  always @(negedge clk) begin
    if (!rst) begin
      prev_start = 1'b0;
      prev_valid = 1'b0;
      job_active = 1'b0;
    end else begin
      if (mul_start) begin
        chk("start_single_cycle", {31'd0, prev_start}, 32'd0);
        n_starts++;
        last_start_cycle = cycle;
        job_a = mul_mplier;
        job_b = mul_mcand;
        job_active = 1'b1;
      end else if (job_active) begin
        chk("mplier_stable", {28'd0, mul_mplier}, {28'd0, job_a});
        chk("mcand_stable", {28'd0, mul_mcand}, {28'd0, job_b});
        if (out_valid) job_active = 1'b0;
      end
      if (out_valid && !prev_valid) first_valid_cycle = cycle;
      prev_start = mul_start;
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {23'd0, out_err, out_product}, 32'hFFFF_FFFF);
        end else begin
          exp_item = exp_q.pop_front();
          $display("result %0d: product=%0d err=%0b (expected product=%0d err=%0b)",
                   n_results, out_product, out_err, exp_item[PW-1:0], exp_item[PW]);
          chk("result", {23'd0, out_err, out_product}, {23'd0, exp_item});
          n_results++;
        end
      end
    end
  end

  // All stimulus changes at posedge+1; tasks return at posedge+1.
  task automatic push(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic err);
    logic acc;
    acc = 1'b0;
    in_valid  = 1'b1;
    in_mplier = a;
    in_mcand  = b;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) exp_q.push_back(err ? {1'b1, 8'h00} : {1'b0, PW'(a) * PW'(b)});
    else chk("push_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input string tag);
    for (int i = 0; i < 3000 && n_results < n; i++) begin
      @(posedge clk);
      #1;
    end
    if (n_results < n) chk(tag, n_results, n);
  endtask

  task automatic wait_valid(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    @(posedge clk);
    #1;
    if (!seen) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_mul_start"}, {31'd0, mul_start}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_err"}, {31'd0, out_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_mul_mplier"}, {28'd0, mul_mplier}, 32'd0);
    chk({tag, "_mul_mcand"}, {28'd0, mul_mcand}, 32'd0);
    chk({tag, "_out_product"}, {24'd0, out_product}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired n_results=%0d", n_results);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0;
    logic busy_seen;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single job
    r0 = n_results; s0 = n_starts;
    push(4'd13, 4'd11, 1'b0);
    idle();
    wait_results(r0 + 1, "t1_result_timeout");
    repeat (5) @(posedge clk);
    #1;
    chk("t1_starts", n_starts - s0, 1);
    chk("t1_beats", n_results - r0, 1);

    // 2: burst of five back-to-back
    r0 = n_results;
    push(4'd3, 4'd5, 1'b0);
    push(4'd15, 4'd15, 1'b0);
    push(4'd0, 4'd9, 1'b0);
    push(4'd1, 4'd1, 1'b0);
    push(4'd7, 4'd8, 1'b0);
    idle();
    wait_results(r0 + 5, "t2_result_timeout");

    // 3: backpressure holds the first result and blocks the next issue
    out_ready = 1'b0;
    r0 = n_results;
    push(4'd3, 4'd5, 1'b0);
    push(4'd2, 4'd6, 1'b0);
    idle();
    wait_valid("t3_valid_timeout");
    s0 = n_starts;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_product", {24'd0, out_product}, 32'd15);
      chk("t3_hold_err", {31'd0, out_err}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("t3_no_second_start", n_starts - s0, 0);
    out_ready = 1'b1;
    wait_results(r0 + 2, "t3_result_timeout");

    // 4: fill to full behind a held result, then keep pushing as slots free
    out_ready = 1'b0;
    r0 = n_results;
    push(4'd4, 4'd4, 1'b0);
    push(4'd5, 4'd3, 1'b0);
    push(4'd6, 4'd2, 1'b0);
    push(4'd9, 4'd9, 1'b0);
    push(4'd10, 4'd10, 1'b0);
    idle();
    repeat (20) @(posedge clk);
    #1;
    chk("t4_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t4_full_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    push(4'd11, 4'd2, 1'b0);
    push(4'd12, 4'd12, 1'b0);
    push(4'd14, 4'd3, 1'b0);
    idle();
    wait_results(r0 + 8, "t4_result_timeout");

    // 5: stub core never leaves ready -> timeout abort, then a normal job
    out_ready = 1'b0;
    core_stub = 1'b1;
    r0 = n_results;
    push(4'd2, 4'd3, 1'b1);
    push(4'd6, 4'd7, 1'b0);
    idle();
    wait_valid("t5_valid_timeout");
    chk("t5_timeout_latency", first_valid_cycle - last_start_cycle, 32);
    @(negedge clk);
    chk("t5_err", {31'd0, out_err}, 32'd1);
    chk("t5_product", {24'd0, out_product}, 32'd0);
    @(posedge clk);
    #1;
    core_stub = 1'b0;
    out_ready = 1'b1;
    wait_results(r0 + 2, "t5_result_timeout");

    // 6: asynchronous reset during WAIT_DONE with two jobs queued
    r0 = n_results;
    push(4'd3, 4'd3, 1'b0);
    push(4'd4, 4'd4, 1'b0);
    push(4'd5, 4'd5, 1'b0);
    idle();
    busy_seen = 1'b0;
    for (int i = 0; i < 100 && !busy_seen; i++) begin
      @(negedge clk);
      busy_seen = !mul_ready;
    end
    chk("t6_core_busy_seen", {31'd0, busy_seen}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("t6_no_results", n_results - r0, 0);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
